spi_master_rd: RTL

SPI_MASTER_RD -- requirements
Module: spi_master_rd

---
 rtl/spi_master_rd.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_rd.sv
// rtl/spi_master_rd.sv - SPI mode-0 frame master: streams DATA_NUM words out on MOSI while capturing MISO
//
// Runs one chip-select frame of DATA_NUM words of DATA_LEN bits, MSB first,
// with spi_clk half-period of HALF_DIV sys_clk cycles.
// Optional feature macro: SPI_MASTER_CS_GAP_EN adds a GAP state that holds
// spi_cs high (busy=1) for CS_GAP cycles after every done or abort.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start, abort         one-cycle frame request / frame termination
//   tx_data, tx_req      next MOSI word, requested one cycle before it is needed
//   rx_data, rx_valid    last MISO word, one-cycle update strobe
//   busy, done           frame in progress / one-cycle normal completion strobe
//   spi_cs, spi_clk      chip select (active low), serial clock
//   spi_mosi, spi_miso   serial data out / in (in is 2-flop synchronised)
module spi_master_rd #(
  parameter int HALF_DIV = 4,
  parameter int DATA_LEN = 8,
  parameter int DATA_NUM = 800,
  parameter int CS_GAP   = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_req,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                done,
  output logic                spi_cs,
  output logic                spi_clk,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int TOTAL_BITS = DATA_LEN * DATA_NUM;
  localparam int BW = $clog2(TOTAL_BITS + 1);
  localparam int IW = $clog2(DATA_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(TOTAL_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_LEN - 1);
  localparam logic [7:0]    DIV_LAST = 8'(HALF_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
`ifdef SPI_MASTER_CS_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_END   = S_GAP;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  logic [GW-1:0] gap_cnt;
`else
  localparam logic [2:0] S_END   = S_IDLE;
`endif

  if (HALF_DIV < 2 || HALF_DIV > 255 || DATA_LEN < 2 || DATA_NUM < 1 || CS_GAP < 1) begin : g_param_check
    $error("spi_master_rd: parameter out of range");
  end

  logic [2:0]          state;
  logic [7:0]          div_cnt;
  logic [BW-1:0]       bit_cnt;   // rising edges so far in the frame, 0..TOTAL_BITS
  logic [IW-1:0]       bit_idx;   // rising edges so far in the current word
  logic [DATA_LEN-2:0] tx_sh;     // bits still to send after the one on spi_mosi
  logic [DATA_LEN-2:0] rx_sh;     // bits received so far in the current word
  logic [DATA_LEN-1:0] rx_word;
  logic                miso_s1, miso_s2;
  logic                half_end;
  logic                in_frame;

  assign half_end = (div_cnt == DIV_LAST);
  assign in_frame = (state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD);
  assign rx_word  = {rx_sh, miso_s2};
  assign busy     = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      done     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
`ifdef SPI_MASTER_CS_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (abort && in_frame) begin
        // Abort also suppresses any tx_req/rx_valid this edge would have raised.
        state    <= S_END;
        spi_cs   <= 1'b1;
        spi_clk  <= 1'b0;
        spi_mosi <= 1'b0;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        bit_idx  <= '0;
`ifdef SPI_MASTER_CS_GAP_EN
        gap_cnt  <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            // done is still high on the first IDLE cycle; a start there is dropped.
            if (start && !done) begin
              state   <= S_SETUP;
              spi_cs  <= 1'b0;
              tx_req  <= 1'b1;
              div_cnt <= '0;
              bit_cnt <= '0;
              bit_idx <= '0;
            end
          end
          S_SETUP: begin
            if (half_end) begin
              div_cnt  <= '0;
              state    <= S_SHIFT;
              tx_sh    <= tx_data[DATA_LEN-2:0];
              spi_mosi <= tx_data[DATA_LEN-1];
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          S_SHIFT: begin
            if (half_end) begin
              div_cnt <= '0;
              spi_clk <= ~spi_clk;
              if (!spi_clk) begin
                rx_sh   <= rx_word[DATA_LEN-2:0];
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_idx == LAST_IDX) begin
                  bit_idx  <= '0;
                  rx_data  <= rx_word;
                  rx_valid <= 1'b1;
                  if ((bit_cnt + 1'b1) != LAST_BIT) tx_req <= 1'b1;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end else begin
                // Falling edge: the final one ends shifting; a word boundary
                // (bit_idx back at 0) loads the word fetched by tx_req.
                if (bit_cnt == LAST_BIT) begin
                  state <= S_HOLD;
                end else if (bit_idx == '0) begin
                  tx_sh    <= tx_data[DATA_LEN-2:0];
                  spi_mosi <= tx_data[DATA_LEN-1];
                end else begin
                  tx_sh    <= tx_sh << 1;
                  spi_mosi <= tx_sh[DATA_LEN-2];
                end
              end
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
          S_HOLD: begin
            if (half_end) begin
              div_cnt  <= '0;
              spi_cs   <= 1'b1;
              spi_mosi <= 1'b0;
              done     <= 1'b1;
              state    <= S_END;
`ifdef SPI_MASTER_CS_GAP_EN
              gap_cnt  <= '0;
`endif
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
`ifdef SPI_MASTER_CS_GAP_EN
          S_GAP: begin
            if (gap_cnt == GAP_LAST) state <= S_IDLE;
            else gap_cnt <= gap_cnt + 1'b1;
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
